otter_crypto_unit: RTL and testbench
====================================

# otter_crypto_unit

Multi-cycle cipher datapath answering the OTTER control unit's ENCRY (opcode 7'b1011011) sequence. The control unit holds EXECUTE for four cycles and broadcasts `crypto_count` 0..3; this block consumes rs1/rs2 and computes a 4-round, 32-bit Feistel encrypt or decrypt. Its result is presented combinationally during the count-3 cycle, when the control unit asserts register write. It sits beside the ALU in the OTTER datapath and feeds the register-file write mux.

## Interface
- No parameters. Round count and the function codes are fixed in the package.
- CRY_CLK  in  1  system clock.
- CRY_RESET  in  1  synchronous, active-high reset.
- CRY_START  in  1  high while the CU is in EXECUTE with opcode ENCRY.
- CRY_COUNT  in  2  the CU's `crypto_count`.
- CRY_FUNC3  in  3  function select:
  - 000 encrypt.
  - 001 decrypt.
  - 010 key load (only with the macro).
  - Any other code is illegal.
- CRY_RS1  in  32  plaintext or ciphertext.
- CRY_RS2  in  32  key.
- CRY_RESULT  out  32  cipher output. Valid only while CRY_VALID is high; 0 otherwise.
- CRY_VALID  out  1  high in the count-3 cycle of a legal sequence.
- CRY_BUSY  out  1  high while the internal round counter is nonzero.
- CRY_ERR  out  1  sticky sequencing or illegal-func3 error.

## Operation
- Block split: L = data[31:16], R = data[15:0].
- Round key: k_i = rotl16(K[15:0]^K[31:16], 3·i) ^ 16'(i), for i = 0..3.
- Round function: F(R,k) = rotl16(R+k mod 2^16, 5) ^ (R>>3).
- Round: L' = R; R' = L ^ F(R,k).
- Output is {R4, L4}, with the final halves swapped.
- Encrypt uses keys k0..k3. Decrypt is the same datapath with keys k3..k0, so decrypt(encrypt(x)) = x.
- Internal state registers:
  - 32-bit block register `blk`.
  - 32-bit latched key `key_q`.
  - Mode bit.
  - 2-bit round counter `rnd`.
- Cycle-by-cycle sequencing, on edges where CRY_START=1:
  - CRY_COUNT = 0: latch key and mode; `blk` ← round0(CRY_RS1); `rnd` ← 1.
  - CRY_COUNT = 1 or 2: `blk` ← round_rnd(`blk`); `rnd` ← `rnd`+1.
  - CRY_COUNT = 3: CRY_RESULT = swap(round3(`blk`)) combinationally; CRY_VALID = 1; `rnd` ← 0 at the edge.
- Mismatch (CRY_START=1 and CRY_COUNT ≠ `rnd`): set CRY_ERR. CRY_VALID is forced to 0 for the rest of the sequence. `rnd` resyncs to CRY_COUNT+1 (mod 4).
- CRY_START dropping mid-sequence: abort; `rnd` ← 0; `blk` is retained; CRY_ERR is set.
- Illegal func3: set CRY_ERR at count 0. CRY_VALID stays 0 at count 3, so the CU writes 0.
- CRY_ERR clears only on reset.

## Timing
- Reset values: all outputs 0; `blk`, `key_q`, `rnd` = 0.
- Latency: 4 cycles from count 0 to result. No bubbles between back-to-back ENCRY instructions; a count-0 edge may directly follow a count-3 edge.
- Rounds 0–2 are registered; round 3 is combinational from `blk` to CRY_RESULT. That path lies in the CU's write-back cycle and must meet single-cycle timing.
- Reset mid-sequence: `rnd` returns to 0; the next CRY_START at count 0 proceeds normally with no error.
- Reset asserted together with CRY_START: reset wins.

## Configuration
- `OTTER_CRYPTO_KEYREG_EN` defined:
  - func3 010 writes CRY_RS2 into a persistent key register at count 0.
  - Its sequence returns CRY_RESULT = 0 with CRY_VALID = 1.
  - Encrypt and decrypt take their key from the key register (reset value 0); CRY_RS2 is ignored.
- Not defined:
  - The key is CRY_RS2 latched at count 0.
  - func3 010 is illegal.

## Structure
- Package `otter_crypto_pkg` holds:
  - the func3 enum `crypto_func_t`;
  - `CRYPTO_ROUNDS = 4`;
  - the ENCRY opcode constant;
  - the functions `round_key(K,i)` and `feistel_f(R,k)`.
- One combinational sub-module, `otter_crypto_round` (inputs block, key, index; output next block). It is instantiated twice: once on the registered path and once on the output path.

## Test plan
- Encrypt of data 0x0000_0000 with key 0x0000_0000, counts 0→3: CRY_RESULT = 0x8848_0444 with CRY_VALID = 1 at count 3 only.
- Decrypt of 0x8848_0444 with key 0 returns 0x0000_0000. Encrypt then decrypt of 0x1234_5678 with key 0xA5A5_0F0F returns 0x1234_5678.
- Count sequence 0, 1, 3: CRY_ERR = 1, CRY_VALID stays 0, CRY_ERR remains set through a following legal sequence until reset.
- Reset pulsed after count 1: all outputs 0; the next 0→3 sequence produces a correct result with CRY_ERR = 0.
- func3 = 011: CRY_ERR = 1, CRY_RESULT = 0 at count 3.
- With `OTTER_CRYPTO_KEYREG_EN`:
  - Key load of 0 followed by encrypt of 0 with CRY_RS2 = 0xFFFF_FFFF gives 0x8848_0444.
  - Back-to-back ENCRY instructions show no gap between sequences.

Source files
------------

// File: rtl/otter_crypto_pkg.sv
// Shared constants, function codes and round helpers for the OTTER cipher unit.
package otter_crypto_pkg;

  typedef enum logic [2:0] {
    FuncEnc = 3'b000,
    FuncDec = 3'b001,
    FuncKey = 3'b010
  } crypto_func_t;

  localparam int unsigned CRYPTO_ROUNDS = 4;
  localparam logic [6:0]  OPCODE_ENCRY  = 7'b1011011;

  function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] n);
    return (x << n) | (x >> (5'd16 - {1'b0, n}));
  endfunction

  function automatic logic [15:0] round_key(input logic [31:0] k, input logic [1:0] i);
    logic [3:0] amt;
    amt = {2'b00, i} + {1'b0, i, 1'b0};
    return rotl16(k[15:0] ^ k[31:16], amt) ^ {14'b0, i};
  endfunction

  function automatic logic [15:0] feistel_f(input logic [15:0] r, input logic [15:0] k);
    logic [15:0] s;
    s = r + k;
    return rotl16(s, 4'd5) ^ (r >> 3);
  endfunction

endpackage

// File: rtl/otter_crypto_unit_if.sv
// Control-unit side bus of the OTTER cipher unit.
interface otter_crypto_unit_if;
    logic        CRY_START;
    logic [1:0]  CRY_COUNT;
    logic [2:0]  CRY_FUNC3;
    logic [31:0] CRY_RS1;
    logic [31:0] CRY_RS2;
    logic [31:0] CRY_RESULT;
    logic        CRY_VALID;
    logic        CRY_BUSY;
    logic        CRY_ERR;

    modport master (
        output CRY_START, CRY_COUNT, CRY_FUNC3, CRY_RS1, CRY_RS2,
        input  CRY_RESULT, CRY_VALID, CRY_BUSY, CRY_ERR
    );

    modport slave (
        input  CRY_START, CRY_COUNT, CRY_FUNC3, CRY_RS1, CRY_RS2,
        output CRY_RESULT, CRY_VALID, CRY_BUSY, CRY_ERR
    );
endinterface

// File: rtl/otter_crypto_round.sv
// One combinational Feistel round: L' = R, R' = L ^ F(R, k_idx).
import otter_crypto_pkg::*;

module otter_crypto_round (
    input  logic [31:0] blk_i,
    input  logic [31:0] key_i,
    input  logic [1:0]  idx_i,
    output logic [31:0] blk_o
);
    logic [15:0] k;

    always_comb begin
        k     = round_key(key_i, idx_i);
        blk_o = {blk_i[15:0], blk_i[31:16] ^ feistel_f(blk_i[15:0], k)};
    end
endmodule

// File: rtl/otter_crypto_unit.sv
// 4-round 32-bit Feistel encrypt/decrypt driven by the CU's crypto_count.
// Optional persistent key register: define OTTER_CRYPTO_KEYREG_EN.
import otter_crypto_pkg::*;

module otter_crypto_unit (
    input  logic                CRY_CLK,
    input  logic                CRY_RESET,
    otter_crypto_unit_if.slave  cry
);
    logic [31:0] blk_q;
    logic [31:0] key_q;
    logic        mode_q;  // 1 = decrypt
    logic [1:0]  rnd_q;
    logic        bad_q;   // current sequence may not report a result
    logic        err_q;
`ifdef OTTER_CRYPTO_KEYREG_EN
    logic [31:0] keyreg_q;
    logic        load_q;
`endif

    crypto_func_t func;
    logic         func_ok;
    logic         func_dec;
    logic         func_load;
    logic [31:0]  key_in;

    assign func = crypto_func_t'(cry.CRY_FUNC3);

    always_comb begin
        func_dec  = (func == FuncDec);
`ifdef OTTER_CRYPTO_KEYREG_EN
        func_ok   = (func == FuncEnc) || (func == FuncDec) || (func == FuncKey);
        func_load = (func == FuncKey);
        key_in    = keyreg_q;
`else
        func_ok   = (func == FuncEnc) || (func == FuncDec);
        func_load = 1'b0;
        key_in    = cry.CRY_RS2;
`endif
    end

    // Registered path: round 0 from rs1 at count 0, rounds 1-2 from blk.
    logic        first;
    logic [31:0] reg_blk_in;
    logic [31:0] reg_key;
    logic        reg_dec;
    logic [1:0]  reg_idx;
    logic [31:0] reg_blk_out;

    assign first      = (cry.CRY_COUNT == 2'd0);
    assign reg_blk_in = first ? cry.CRY_RS1 : blk_q;
    assign reg_key    = first ? key_in : key_q;
    assign reg_dec    = first ? func_dec : mode_q;
    assign reg_idx    = reg_dec ? ~cry.CRY_COUNT : cry.CRY_COUNT;

    otter_crypto_round u_round_reg (
        .blk_i (reg_blk_in),
        .key_i (reg_key),
        .idx_i (reg_idx),
        .blk_o (reg_blk_out)
    );

    // Output path: last round is combinational into the write-back cycle.
    logic [1:0]  out_idx;
    logic [31:0] out_blk;

    assign out_idx = mode_q ? 2'd0 : 2'(CRYPTO_ROUNDS - 1);

    otter_crypto_round u_round_out (
        .blk_i (blk_q),
        .key_i (key_q),
        .idx_i (out_idx),
        .blk_o (out_blk)
    );

    always_ff @(posedge CRY_CLK) begin
        if (CRY_RESET) begin
            blk_q  <= '0;
            key_q  <= '0;
            mode_q <= 1'b0;
            rnd_q  <= '0;
            bad_q  <= 1'b0;
            err_q  <= 1'b0;
`ifdef OTTER_CRYPTO_KEYREG_EN
            keyreg_q <= '0;
            load_q   <= 1'b0;
`endif
        end else if (cry.CRY_START) begin
            // Legal or not, the counter follows the CU so later counts line up.
            rnd_q <= cry.CRY_COUNT + 2'd1;
            if (cry.CRY_COUNT != rnd_q) begin
                err_q <= 1'b1;
                bad_q <= 1'b1;
            end else if (first) begin
                key_q  <= key_in;
                mode_q <= func_dec;
                blk_q  <= reg_blk_out;
                bad_q  <= !func_ok;
                if (!func_ok) err_q <= 1'b1;
`ifdef OTTER_CRYPTO_KEYREG_EN
                load_q <= func_load;
                if (func_load) keyreg_q <= cry.CRY_RS2;
`endif
            end else if (cry.CRY_COUNT != 2'd3) begin
                blk_q <= reg_blk_out;
            end
        end else if (rnd_q != 2'd0) begin
            rnd_q <= '0;
            err_q <= 1'b1;
        end
    end

    logic valid;
    logic load_seq;

    assign valid = !CRY_RESET && cry.CRY_START && (cry.CRY_COUNT == 2'd3) &&
                   (rnd_q == 2'd3) && !bad_q;
`ifdef OTTER_CRYPTO_KEYREG_EN
    assign load_seq = load_q;
`else
    assign load_seq = 1'b0;
`endif

    assign cry.CRY_VALID  = valid;
    assign cry.CRY_RESULT = (valid && !load_seq) ? {out_blk[15:0], out_blk[31:16]} : 32'd0;
    assign cry.CRY_BUSY   = (rnd_q != 2'd0);
    assign cry.CRY_ERR    = err_q;

    logic unused_func_load;
    assign unused_func_load = func_load;
endmodule

// File: tb/tb_otter_crypto_unit.sv
// Self-checking bench for otter_crypto_unit against a behavioural Feistel model.
module tb_otter_crypto_unit;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    otter_crypto_unit_if bus ();

    otter_crypto_unit dut (
        .CRY_CLK   (clk),
        .CRY_RESET (reset),
        .cry       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] o_result;
    logic        o_valid;
    logic        o_busy;
    logic        o_err;
    logic        v_early;
    logic [31:0] kreg;

    function automatic logic [31:0] model_cipher(input logic [31:0] d, input logic [31:0] k,
                                                 input bit dec);
        logic [15:0] l, r, t, kb, ki, s;
        logic [31:0] dbl;
        int j;
        l  = d[31:16];
        r  = d[15:0];
        kb = k[15:0] ^ k[31:16];
        for (int i = 0; i < 4; i++) begin
            j   = dec ? 3 - i : i;
            dbl = {kb, kb} << (3 * j);
            ki  = dbl[31:16] ^ 16'(j);
            s   = r + ki;
            dbl = {s, s} << 5;
            t   = l ^ (dbl[31:16] ^ (r >> 3));
            l   = r;
            r   = t;
        end
        return {r, l};
    endfunction

    function automatic logic [31:0] key_for(input logic [31:0] rs2);
`ifdef OTTER_CRYPTO_KEYREG_EN
        return kreg;
`else
        return rs2;
`endif
    endfunction

    task automatic step(input bit rst, input bit st, input logic [1:0] cnt,
                        input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        reset         = rst;
        bus.CRY_START = st;
        bus.CRY_COUNT = cnt;
        bus.CRY_FUNC3 = f;
        bus.CRY_RS1   = a;
        bus.CRY_RS2   = b;
        #1;
        o_result = bus.CRY_RESULT;
        o_valid  = bus.CRY_VALID;
        o_busy   = bus.CRY_BUSY;
        o_err    = bus.CRY_ERR;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
        kreg = 32'd0;
        idle();
    endtask

    // Full 0..3 sequence; outputs of the count-3 cycle left in o_*.
    task automatic run_seq(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        v_early = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1, 2'(c), f, a, b);
            v_early = v_early | o_valid;
        end
        step(1'b0, 1'b1, 2'd3, f, a, b);
    endtask

    task automatic load_key(input logic [31:0] k);
`ifdef OTTER_CRYPTO_KEYREG_EN
        run_seq(3'b010, 32'd0, k);
        kreg = k;
`endif
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_result !== 32'd0 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got res=%h v=%b b=%b e=%b, want all 0",
                     o_result, o_valid, o_busy, o_err);
        end
    endtask

    task automatic test_known();
        logic [31:0] ct;
        load_key(32'd0);
        run_seq(3'b000, 32'd0, 32'd0);
        checks++;
        if (v_early !== 1'b0) begin
            errors++;
            $display("FAIL known_valid_early: got %b want 0", v_early);
        end
        checks++;
        if (o_valid !== 1'b1 || o_result !== 32'h8848_0444) begin
            errors++;
            $display("FAIL known_enc0: got v=%b res=%h want v=1 res=88480444", o_valid, o_result);
        end
        run_seq(3'b001, 32'h8848_0444, 32'd0);
        checks++;
        if (o_valid !== 1'b1 || o_result !== 32'd0) begin
            errors++;
            $display("FAIL known_dec0: got v=%b res=%h want v=1 res=00000000", o_valid, o_result);
        end
        load_key(32'hA5A5_0F0F);
        run_seq(3'b000, 32'h1234_5678, 32'hA5A5_0F0F);
        ct = o_result;
        checks++;
        if (ct !== model_cipher(32'h1234_5678, 32'hA5A5_0F0F, 1'b0)) begin
            errors++;
            $display("FAIL known_enc_key: got %h want %h", ct,
                     model_cipher(32'h1234_5678, 32'hA5A5_0F0F, 1'b0));
        end
        run_seq(3'b001, ct, 32'hA5A5_0F0F);
        checks++;
        if (o_result !== 32'h1234_5678) begin
            errors++;
            $display("FAIL known_roundtrip: got %h want 12345678", o_result);
        end
        idle();
        checks++;
        if (o_busy !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL known_after: got busy=%b err=%b want 0 0", o_busy, o_err);
        end
    endtask

    // Back-to-back random sequences with no idle cycles between them.
    task automatic test_back_to_back();
        logic [2:0]  f;
        logic [31:0] a, b, exp;
        for (int n = 0; n < 24; n++) begin
`ifdef OTTER_CRYPTO_KEYREG_EN
            f = 3'($urandom_range(0, 2));
`else
            f = 3'($urandom_range(0, 1));
`endif
            a = $urandom;
            b = $urandom;
            exp = (f == 3'b010) ? 32'd0 : model_cipher(a, key_for(b), f[0]);
            v_early = 1'b0;
            step(1'b0, 1'b1, 2'd0, f, a, b);
            v_early = o_valid;
            step(1'b0, 1'b1, 2'd1, f, a, b);
            v_early = v_early | o_valid;
            step(1'b0, 1'b1, 2'd2, f, a, b);
            checks++;
            if (o_busy !== 1'b1 || (v_early | o_valid) !== 1'b0) begin
                errors++;
                $display("FAIL b2b_mid[%0d]: got busy=%b v=%b want busy=1 v=0",
                         n, o_busy, v_early | o_valid);
            end
            step(1'b0, 1'b1, 2'd3, f, a, b);
            checks++;
            if (o_valid !== 1'b1 || o_result !== exp) begin
                errors++;
                $display("FAIL b2b_res[%0d]: f=%0d a=%h b=%h got v=%b res=%h want v=1 res=%h",
                         n, f, a, b, o_valid, o_result, exp);
            end
            if (f == 3'b010) kreg = b;
        end
        idle();
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err: got %b want 0", o_err);
        end
    endtask

    task automatic test_mismatch();
        logic [31:0] a;
        a = $urandom;
        step(1'b0, 1'b1, 2'd0, 3'b000, a, 32'h0BAD_F00D);
        step(1'b0, 1'b1, 2'd1, 3'b000, a, 32'h0BAD_F00D);
        step(1'b0, 1'b1, 2'd3, 3'b000, a, 32'h0BAD_F00D);
        checks++;
        if (o_valid !== 1'b0 || o_result !== 32'd0) begin
            errors++;
            $display("FAIL mismatch_valid: got v=%b res=%h want 0 0", o_valid, o_result);
        end
        idle();
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_err: got %b want 1", o_err);
        end
        run_seq(3'b000, a, 32'h0BAD_F00D);
        checks++;
        if (o_valid !== 1'b1 || o_result !== model_cipher(a, key_for(32'h0BAD_F00D), 1'b0)
            || o_err !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_follow: got v=%b res=%h err=%b want v=1 res=%h err=1",
                     o_valid, o_result, o_err, model_cipher(a, key_for(32'h0BAD_F00D), 1'b0));
        end
        idle();
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_sticky: got %b want 1", o_err);
        end
        do_reset();
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_clear: got %b want 0", o_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        step(1'b0, 1'b1, 2'd0, 3'b001, a, b);
        step(1'b0, 1'b1, 2'd1, 3'b001, a, b);
        do_reset();
        checks++;
        if (o_result !== 32'd0 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL resetmid_outputs: got res=%h v=%b b=%b e=%b want all 0",
                     o_result, o_valid, o_busy, o_err);
        end
        run_seq(3'b000, a, b);
        checks++;
        if (o_valid !== 1'b1 || o_result !== model_cipher(a, key_for(b), 1'b0)) begin
            errors++;
            $display("FAIL resetmid_seq: got v=%b res=%h want v=1 res=%h",
                     o_valid, o_result, model_cipher(a, key_for(b), 1'b0));
        end
        idle();
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL resetmid_err: got %b want 0", o_err);
        end
    endtask

    task automatic test_illegal();
        run_seq(3'b011, 32'hDEAD_BEEF, 32'h1111_2222);
        checks++;
        if (o_valid !== 1'b0 || o_result !== 32'd0 || o_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_func: got v=%b res=%h err=%b want v=0 res=0 err=1",
                     o_valid, o_result, o_err);
        end
        do_reset();
    endtask

    task automatic test_abort();
        step(1'b0, 1'b1, 2'd0, 3'b000, 32'h5555_AAAA, 32'd7);
        step(1'b0, 1'b1, 2'd1, 3'b000, 32'h5555_AAAA, 32'd7);
        idle();
        idle();
        checks++;
        if (o_err !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort: got err=%b busy=%b want err=1 busy=0", o_err, o_busy);
        end
        do_reset();
    endtask

`ifdef OTTER_CRYPTO_KEYREG_EN
    task automatic test_keyreg();
        run_seq(3'b010, 32'h1234_5678, 32'd0);
        kreg = 32'd0;
        checks++;
        if (o_valid !== 1'b1 || o_result !== 32'd0) begin
            errors++;
            $display("FAIL keyload: got v=%b res=%h want v=1 res=0", o_valid, o_result);
        end
        run_seq(3'b000, 32'd0, 32'hFFFF_FFFF);
        checks++;
        if (o_valid !== 1'b1 || o_result !== 32'h8848_0444) begin
            errors++;
            $display("FAIL keyreg_enc: got v=%b res=%h want v=1 res=88480444", o_valid, o_result);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        kreg   = 32'd0;
        reset  = 1'b1;
        bus.CRY_START = 1'b0;
        bus.CRY_COUNT = 2'd0;
        bus.CRY_FUNC3 = 3'd0;
        bus.CRY_RS1   = 32'd0;
        bus.CRY_RS2   = 32'd0;
        test_reset();
        test_known();
        test_back_to_back();
        test_mismatch();
        test_reset_mid();
        test_illegal();
        test_abort();
`ifdef OTTER_CRYPTO_KEYREG_EN
        test_keyreg();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
